// File: rtl/iob_cache_invalidate_ctrl.sv
// iob_cache_invalidate_ctrl
// Runs a full cache invalidation when the control unit pulses inv_req.
// It waits for the write-through buffer to drain, then clears every line
// index of the valid/tag memories, one index per cycle.
//
// Ports:
//   clk          clock
//   reset        asynchronous, active-high reset
//   inv_req      invalidate request pulse from the control unit
//   wtbuf_empty  write-through buffer is empty
//   cnt_clr      synchronous clear of inv_cnt
//   inv_we       clear strobe to the valid memory (one line per cycle)
//   inv_addr     line index being cleared
//   busy         front-end hold while an invalidation is in progress
//   done         one-cycle pulse when a sweep completes
//   inv_cnt      number of completed sweeps, saturating
//
// state | meaning
// IDLE  | no invalidation in progress, front-end free
// DRAIN | waiting for the write-through buffer to empty
// SWEEP | clearing line inv_addr this cycle
// DONE  | sweep finished, done pulse, counter update
module iob_cache_invalidate_ctrl #(
  parameter int LINE_OFF_W = 7,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inv_req,
  input  logic                  wtbuf_empty,
  input  logic                  cnt_clr,
  output logic                  inv_we,
  output logic [LINE_OFF_W-1:0] inv_addr,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      inv_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_SWEEP = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [LINE_OFF_W-1:0] ADDR_LAST = '1;
  localparam logic [LINE_OFF_W-1:0] ADDR_ONE  = LINE_OFF_W'(1);
  localparam logic [CNT_W-1:0]      CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);

  state_t                state_q, state_d;
  logic                  pending_q, pending_d;
  logic [LINE_OFF_W-1:0] addr_q, addr_d;
  logic                  inv_we_d, busy_d, done_d;

  // State register; outputs are registered from the next-state decode so
  // they line up with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pending_q <= 1'b0;
      addr_q    <= '0;
      inv_we    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      inv_cnt   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      addr_q    <= addr_d;
      inv_we    <= inv_we_d;
      busy      <= busy_d;
      done      <= done_d;
      if (cnt_clr)
        inv_cnt <= '0;
      else if (state_q == S_DONE && inv_cnt != CNT_MAX)
        inv_cnt <= inv_cnt + CNT_ONE;
    end
  end

  assign inv_addr = addr_q;

  // Next-state logic. Requests seen while already running collapse into a
  // single pending flag; a request landing in DONE is picked up from IDLE.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    addr_d    = addr_q;
    if (inv_req && state_q != S_IDLE)
      pending_d = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (inv_req || pending_q) begin
          state_d   = S_DRAIN;
          pending_d = 1'b0;
        end
      end
      S_DRAIN: begin
        addr_d = '0;
        if (wtbuf_empty)
          state_d = S_SWEEP;
      end
      S_SWEEP: begin
        // Wraps to zero on the last index, ready for the next sweep.
        addr_d = addr_q + ADDR_ONE;
        if (addr_q == ADDR_LAST)
          state_d = S_DONE;
      end
      S_DONE: begin
        if (pending_q) begin
          state_d   = S_DRAIN;
          pending_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode of the upcoming state.
  always_comb begin
    inv_we_d = (state_d == S_SWEEP);
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
  end

endmodule

// File: tb/tb_iob_cache_invalidate_ctrl.sv
module tb_iob_cache_invalidate_ctrl;

  localparam int LW = 3;
  localparam int CW = 2;
  localparam int NL = 1 << LW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          inv_req = 1'b0;
  logic          wtbuf_empty = 1'b1;
  logic          cnt_clr = 1'b0;
  logic          inv_we;
  logic [LW-1:0] inv_addr;
  logic          busy;
  logic          done;
  logic [CW-1:0] inv_cnt;

  iob_cache_invalidate_ctrl #(.LINE_OFF_W(LW), .CNT_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .inv_req     (inv_req),
    .wtbuf_empty (wtbuf_empty),
    .cnt_clr     (cnt_clr),
    .inv_we      (inv_we),
    .inv_addr    (inv_addr),
    .busy        (busy),
    .done        (done),
    .inv_cnt     (inv_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit is_done;
    int cyc;
    int addr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Monitor: every strobe or done pulse must match the next expected event.
  always @(negedge clk) begin
    if (inv_we || done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: cyc=%0d inv_we=%0b done=%0b addr=%0d, required none",
                 cyc, inv_we, done, inv_addr);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.is_done != done || mon_e.is_done == inv_we || mon_e.cyc != cyc ||
            (!mon_e.is_done && mon_e.addr != int'(inv_addr))) begin
          errors++;
          $display("FAIL event: got cyc=%0d we=%0b done=%0b addr=%0d, required cyc=%0d done=%0b addr=%0d",
                   cyc, inv_we, done, inv_addr, mon_e.cyc, mon_e.is_done, mon_e.addr);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic pulse(output int c0);
    @(negedge clk);
    inv_req = 1'b1;
    c0 = cyc;
    @(negedge clk);
    inv_req = 1'b0;
  endtask

  task automatic push_sweep(input int first, input int done_c);
    for (int i = 0; i < NL; i++) exp_q.push_back('{1'b0, first + i, i});
    exp_q.push_back('{1'b1, done_c, 0});
  endtask

  int c0;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_inv_we", int'(inv_we), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_inv_addr", int'(inv_addr), 0);
    chk("rst_inv_cnt", int'(inv_cnt), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Basic sweep
    pulse(c0);
    push_sweep(c0 + 2, c0 + 10);
    chk("basic_busy_c1", int'(busy), 1);
    chk("basic_we_c1", int'(inv_we), 0);
    wait_until(c0 + 10);
    chk("basic_busy_c10", int'(busy), 1);
    wait_until(c0 + 11);
    chk("basic_busy_c11", int'(busy), 0);
    chk("basic_cnt", int'(inv_cnt), 1);

    // Drain wait
    wtbuf_empty = 1'b0;
    pulse(c0);
    push_sweep(c0 + 21, c0 + 29);
    wait_until(c0 + 20);
    chk("drain_busy_c20", int'(busy), 1);
    chk("drain_we_c20", int'(inv_we), 0);
    wtbuf_empty = 1'b1;
    wait_until(c0 + 30);
    chk("drain_busy_c30", int'(busy), 0);
    chk("drain_cnt", int'(inv_cnt), 2);

    // Clear then coalesced pending
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    chk("clr_cnt", int'(inv_cnt), 0);
    pulse(c0);
    push_sweep(c0 + 2, c0 + 10);
    push_sweep(c0 + 12, c0 + 20);
    for (int k = 3; k <= 7; k += 2) begin
      wait_until(c0 + k);
      inv_req = 1'b1;
      @(negedge clk);
      inv_req = 1'b0;
    end
    wait_until(c0 + 11);
    chk("coal_busy_c11", int'(busy), 1);
    chk("coal_we_c11", int'(inv_we), 0);
    wait_until(c0 + 21);
    chk("coal_busy_c21", int'(busy), 0);
    wait_until(c0 + 23);
    chk("coal_idle_c23", int'(busy), 0);
    chk("coal_cnt", int'(inv_cnt), 2);

    // Clear wins over increment in DONE
    pulse(c0);
    push_sweep(c0 + 2, c0 + 10);
    wait_until(c0 + 10);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    chk("clr_prio_cnt", int'(inv_cnt), 0);

    // Saturation over five sweeps
    for (int s = 1; s <= 5; s++) begin
      pulse(c0);
      push_sweep(c0 + 2, c0 + 10);
      wait_until(c0 + 11);
      chk($sformatf("sat_cnt_%0d", s), int'(inv_cnt), (s > 3) ? 3 : s);
    end

    // wtbuf_empty toggling during the sweep has no effect
    pulse(c0);
    push_sweep(c0 + 2, c0 + 10);
    for (int k = 2; k <= 9; k++) begin
      wait_until(c0 + k);
      wtbuf_empty = k[0];
    end
    wtbuf_empty = 1'b1;
    wait_until(c0 + 11);
    chk("toggle_busy_c11", int'(busy), 0);

    // Reset mid-sweep at the cycle showing inv_addr = 4
    pulse(c0);
    for (int i = 0; i <= 4; i++) exp_q.push_back('{1'b0, c0 + 2 + i, i});
    wait_until(c0 + 6);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_we", int'(inv_we), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_cnt", int'(inv_cnt), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_cnt", int'(inv_cnt), 0);

    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/iob_cache_invalidate_ctrl.md
Name: iob_cache_invalidate_ctrl

Overview:
- Sequences a full cache invalidation after the control unit issues its one-cycle invalidate pulse.
- Waits for the write-through buffer to drain, then sweeps every line index, driving a clear strobe to the valid/tag memories.
- Holds the front-end via busy while it runs and signals completion.
- Sits between the cache control unit, the write-through buffer and the valid-bit memory.

Parameters:
- LINE_OFF_W, 7, line index width; number of lines = 2**LINE_OFF_W.
- CNT_W, 32, width of the completed-invalidation counter.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- inv_req  in  1  invalidate request pulse from the control unit
- wtbuf_empty  in  1  write-through buffer empty
- cnt_clr  in  1  synchronous clear of inv_cnt
- inv_we  out  1  clear strobe to the valid memory; one line cleared per cycle
- inv_addr  out  LINE_OFF_W  line index being cleared
- busy  out  1  front-end hold; no new cache access is accepted while high
- done  out  1  one-cycle pulse when a sweep completes
- inv_cnt  out  CNT_W  number of completed sweeps, saturating

Behaviour:
- Reset: async, takes effect immediately, including mid-sweep; the partial sweep is abandoned.
  - State IDLE; pending=0.
  - inv_we=0, inv_addr=0, busy=0, done=0, inv_cnt=0.
- All outputs are registered; state changes on the rising clk edge.
- IDLE:
  - busy=0, inv_we=0.
  - inv_req=1 → DRAIN next cycle.
- DRAIN: busy=1, inv_we=0.
  - Leaves on the first cycle wtbuf_empty=1 is sampled → SWEEP next cycle.
  - No timeout; waits indefinitely.
- SWEEP: busy=1, inv_we=1.
  - inv_addr starts at 0 and increments by 1 each cycle.
  - The cycle with inv_addr = 2**LINE_OFF_W-1 is the last; next state is DONE, and inv_addr wraps to 0.
  - Exactly 2**LINE_OFF_W strobes, no gaps, every index once in ascending order.
  - wtbuf_empty is ignored in this state.
- DONE: busy=1, inv_we=0, done=1 for this single cycle; inv_cnt increments.
  - If pending=1: next state DRAIN and pending clears.
  - Otherwise next state IDLE.
- Minimum latency with buffer already empty, inv_req in cycle 0:
  - DRAIN in cycle 1.
  - SWEEP in cycles 2 to 2**LINE_OFF_W+1.
  - DONE in cycle 2**LINE_OFF_W+2; IDLE the cycle after.
  - busy is high from cycle 1 through DONE.
- inv_req arriving in DRAIN, SWEEP or DONE:
  - Sets pending; it does not restart the current sweep.
  - Multiple requests coalesce into one pending sweep.
- inv_cnt:
  - Increments by 1 on each DONE cycle.
  - Saturates at all-ones and does not wrap.
  - cnt_clr=1 zeros it next cycle; if cnt_clr and DONE coincide, the clear wins (result 0).
- inv_req and reset together: reset wins.

Test Plan:
- Basic sweep (LINE_OFF_W=3, wtbuf_empty=1), inv_req pulse at cycle 0:
  - busy=1 in cycles 1–10.
  - inv_we=1 in cycles 2–9 with inv_addr 0,1,…,7.
  - done=1 only in cycle 10; inv_cnt=1; idle in cycle 11.
- Drain wait:
  - Stimulus: wtbuf_empty=0 until cycle 20, inv_req at cycle 0.
  - Required: state holds DRAIN, inv_we=0 through cycle 20; first strobe with inv_addr=0 in cycle 21; done in cycle 29.
- Coalesced pending:
  - Stimulus: inv_req at cycle 0, plus three more pulses during the sweep.
  - Required: first done at cycle 10, second sweep's DRAIN at cycle 11, second done at cycle 20, then IDLE; inv_cnt=2.
- Reset mid-sweep:
  - Stimulus: reset asserted at the cycle where inv_addr=4.
  - Required: inv_we, busy, done and inv_cnt read 0 immediately; IDLE after release; no done pulse.
- Counter rules:
  - Saturation: with CNT_W=2, 5 sweeps → inv_cnt stays 3.
  - Clear priority: cnt_clr asserted in a DONE cycle → inv_cnt=0 next cycle.
- wtbuf_empty toggling during SWEEP → strobe sequence unaffected; 8 contiguous strobes.
